// File: rtl/b_to_t_encoder.sv
// Binary-to-temporal encoder: latches one value vector per gamma cycle and
// emits per-channel spikes whose onset phase equals the channel's value.

module b_to_t_lane #(
    parameter int VALUE_WIDTH = 4,
    parameter int PULSE_WIDTH = 8
) (
    input  logic                   aclk,
    input  logic                   grst_n,
    input  logic                   act_valid,
    input  logic                   act_mask,
    input  logic [VALUE_WIDTH-1:0] act_value,
    input  logic [VALUE_WIDTH-1:0] phase,
    output logic                   spike
);
    localparam int W = VALUE_WIDTH + 1;

    // One extra bit so value+PULSE_WIDTH never wraps past the gamma cycle
    logic [W-1:0] lo, hi, ph;
    logic         hit;

    assign lo  = {1'b0, act_value};
    assign hi  = lo + W'(PULSE_WIDTH);
    assign ph  = {1'b0, phase};
    assign hit = act_valid && act_mask && (ph >= lo) && (ph < hi);

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) spike <= 1'b0;
        else         spike <= hit;
    end
endmodule

module b_to_t_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CHANNELS      = 4,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                                     aclk,
    input  logic                                     grst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [NUM_CHANNELS-1:0][VALUE_WIDTH-1:0] in_values,
    input  logic [NUM_CHANNELS-1:0]                  in_mask,
    output logic [NUM_CHANNELS-1:0]                  spikes,
    output logic                                     gamma_start,
    output logic                                     underrun
);
    logic [VALUE_WIDTH-1:0] phase, phase_nxt;
    logic                   wrap, accept;

    logic [NUM_CHANNELS-1:0][VALUE_WIDTH-1:0] pend_values, act_values, act_values_nxt;
    logic [NUM_CHANNELS-1:0]                  pend_mask, act_mask, act_mask_nxt;
    logic                                     pend_valid, pend_valid_nxt;
    logic                                     act_valid, act_valid_nxt;

    assign phase_nxt = phase + VALUE_WIDTH'(1);
    assign wrap      = (phase == VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1));
    assign accept    = in_valid && in_ready;

    // The boundary sees pend_valid before this edge's accept, so a wrap-cycle
    // transfer waits one full gamma cycle in the shadow buffer.
    always_comb begin
        pend_valid_nxt = pend_valid;
        act_valid_nxt  = act_valid;
        act_values_nxt = act_values;
        act_mask_nxt   = act_mask;
        if (wrap) begin
            act_valid_nxt = pend_valid;
            if (pend_valid) begin
                act_values_nxt = pend_values;
                act_mask_nxt   = pend_mask;
                pend_valid_nxt = 1'b0;
            end
        end
        if (accept) pend_valid_nxt = 1'b1;
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            phase       <= '0;
            pend_valid  <= 1'b0;
            pend_values <= '0;
            pend_mask   <= '0;
            act_valid   <= 1'b0;
            act_values  <= '0;
            act_mask    <= '0;
            in_ready    <= 1'b1;
            gamma_start <= 1'b1;
            underrun    <= 1'b0;
        end else begin
            phase      <= phase_nxt;
            pend_valid <= pend_valid_nxt;
            if (accept) begin
                pend_values <= in_values;
                pend_mask   <= in_mask;
            end
            act_valid   <= act_valid_nxt;
            act_values  <= act_values_nxt;
            act_mask    <= act_mask_nxt;
            in_ready    <= !pend_valid_nxt;
            gamma_start <= (phase_nxt == '0);
            underrun    <= wrap && !pend_valid;
        end
    end

    // Lanes evaluate the next-cycle state so spikes move on the same edge as phase
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        b_to_t_lane #(
            .VALUE_WIDTH (VALUE_WIDTH),
            .PULSE_WIDTH (PULSE_WIDTH)
        ) u_lane (
            .aclk      (aclk),
            .grst_n    (grst_n),
            .act_valid (act_valid_nxt),
            .act_mask  (act_mask_nxt[i]),
            .act_value (act_values_nxt[i]),
            .phase     (phase_nxt),
            .spike     (spikes[i])
        );
    end
endmodule

// File: tb/tb_b_to_t_encoder.sv
// Bench for b_to_t_encoder: table of vectors with hand-derived spike trains,
// scoreboard keyed by the gamma cycle each vector must play in.

module tb_b_to_t_encoder;
    localparam int G  = 16;
    localparam int PW = 8;
    localparam int NC = 4;
    localparam int VW = 4;

    logic                   aclk = 1'b0;
    logic                   grst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [NC-1:0][VW-1:0]  in_values = '0;
    logic [NC-1:0]          in_mask = '0;
    logic [NC-1:0]          spikes;
    logic                   gamma_start;
    logic                   underrun;

    always #5 aclk = ~aclk;

    b_to_t_encoder #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (PW),
        .NUM_CHANNELS      (NC)
    ) dut (
        .aclk        (aclk),
        .grst_n      (grst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_values   (in_values),
        .in_mask     (in_mask),
        .spikes      (spikes),
        .gamma_start (gamma_start),
        .underrun    (underrun)
    );

    typedef struct {
        logic [NC-1:0][VW-1:0] v;
        logic [NC-1:0]         m;
        logic [NC-1:0][G-1:0]  e;
    } vec_t;

    typedef struct {
        int                   g;
        logic [NC-1:0][G-1:0] e;
    } sb_t;

    vec_t                 tbl[5];
    sb_t                  sbq[$];
    logic [NC-1:0][G-1:0] cur_e;
    logic [NC-1:0][G-1:0] tr;
    int                   n_cmp = 0;
    int                   n_fail = 0;
    int                   tb_phase = 0;
    int                   tb_g = 0;
    int                   acc_phase = 0;
    logic                 acc = 1'b0;

    function automatic vec_t mk(input int v0, input int v1, input int v2, input int v3,
                                input logic [3:0] m,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        vec_t r;
        r.v[0] = VW'(v0); r.v[1] = VW'(v1); r.v[2] = VW'(v2); r.v[3] = VW'(v3);
        r.m = m;
        r.e[0] = e0; r.e[1] = e1; r.e[2] = e2; r.e[3] = e3;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (gamma %0d phase %0d)",
                     name, act, exp, tb_g, tb_phase);
        end
    endtask

    // Check the current cycle, take the handshake, advance one clock.
    task automatic tick();
        sb_t s;
        logic [NC-1:0][G-1:0] exp_e;
        logic exp_un;
        cmp("gamma_start", gamma_start, tb_phase == 0);
        exp_un = (tb_phase == 0) && (tb_g > 0) && !(sbq.size() > 0 && sbq[0].g == tb_g);
        cmp("underrun", underrun, exp_un);
        if (tb_phase == 0) tr = '0;
        for (int c = 0; c < NC; c++) tr[c][tb_phase] = spikes[c];
        if (tb_phase == G - 1) begin
            exp_e = '0;
            if (sbq.size() > 0 && sbq[0].g == tb_g) begin
                s = sbq.pop_front();
                exp_e = s.e;
            end
            for (int c = 0; c < NC; c++)
                cmp($sformatf("spikes_ch%0d", c), tr[c], exp_e[c]);
        end
        acc = in_valid && in_ready;
        if (acc) begin
            acc_phase = tb_phase;
            s.g = tb_g + ((tb_phase == G - 1) ? 2 : 1);
            s.e = cur_e;
            sbq.push_back(s);
        end
        @(posedge aclk);
        tb_phase = (tb_phase + 1) % G;
        if (tb_phase == 0) tb_g++;
        @(negedge aclk);
    endtask

    task automatic wait_phase(input int p);
        while (tb_phase != p) tick();
    endtask

    task automatic send(input int idx);
        cur_e     = tbl[idx].e;
        in_values = tbl[idx].v;
        in_mask   = tbl[idx].m;
        in_valid  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) cmp("send_timeout", 0, 1);
    endtask

    task automatic do_reset();
        grst_n = 1'b0;
        sbq.delete();
        tb_phase = 0;
        tb_g = 0;
        tr = '0;
        repeat (2) @(negedge aclk);
        grst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = mk(0, 3, 9, 15, 4'b1111, 16'h00FF, 16'h07F8, 16'hFE00, 16'h8000);
        tbl[1] = mk(2, 2, 2, 2,  4'b0101, 16'h03FC, 16'h0000, 16'h03FC, 16'h0000);
        tbl[2] = mk(7, 8, 1, 12, 4'b1010, 16'h0000, 16'hFF00, 16'h0000, 16'hF000);
        tbl[3] = mk(5, 0, 14, 6, 4'b1111, 16'h1FE0, 16'h00FF, 16'hC000, 16'h3FC0);
        tbl[4] = mk(15, 1, 8, 4, 4'b0110, 16'h0000, 16'h01FE, 16'hFF00, 16'h0000);
        cur_e = '0;

        @(negedge aclk);
        do_reset();
        repeat (40) tick();

        // One vector per gamma cycle, streamed back-to-back
        for (int i = 0; i < 5; i++) begin
            wait_phase(2);
            send(i);
        end

        // Backpressure: A at phase 4, B held until the shadow buffer drains
        wait_phase(0);
        wait_phase(4);
        send(2);
        cmp("bp_a_phase", acc_phase, 4);
        send(3);
        cmp("bp_b_phase", acc_phase, 0);

        // Accept on the wrap cycle with an empty shadow buffer
        wait_phase(0);
        wait_phase(15);
        send(4);
        cmp("wrap_acc_phase", acc_phase, 15);
        for (int k = 0; k < 4 * G && sbq.size() > 0; k++) tick();
        cmp("sb_drained", sbq.size(), 0);
        wait_phase(0);

        // Mid-gamma reset while ch0 spikes and another vector is pending
        wait_phase(2);
        send(0);
        wait_phase(0);
        send(1);
        wait_phase(6);
        cmp("pre_rst_ch0", spikes[0], 1);
        grst_n = 1'b0;
        #1;
        cmp("rst_spikes", spikes, 0);
        cmp("rst_in_ready", in_ready, 1);
        cmp("rst_gamma_start", gamma_start, 1);
        cmp("rst_underrun", underrun, 0);
        @(negedge aclk);
        do_reset();
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/b_to_t_encoder.md
# b_to_t_encoder

Binary-to-temporal encoder feeding the temporal `select` inputs of the downstream binary/temporal mux stage. Each gamma cycle it converts a latched vector of binary values into per-channel spikes whose rising edge falls at phase offset equal to the value, each lasting `PULSE_WIDTH` cycles. Input values enter through a valid/ready handshake into a one-entry shadow buffer. The buffer is promoted to the active set at each gamma-cycle boundary, so spike trains are never modified mid-cycle.

## Interface
- `GAMMA_CYCLE_WIDTH`, 16: cycles per gamma cycle; must be a power of 2, ≥ 2.
- `PULSE_WIDTH`, 8: spike length in cycles; 1 ≤ `PULSE_WIDTH` ≤ `GAMMA_CYCLE_WIDTH`.
- `NUM_CHANNELS`, 4: number of independent spike outputs.
- `VALUE_WIDTH`, `$clog2(GAMMA_CYCLE_WIDTH)`: bits per binary value.

Ports:
- `aclk`  in  1  clock; all state on rising edge.
- `grst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_values`/`in_mask` valid.
- `in_ready`  out  1  shadow buffer empty; a transfer occurs when `in_valid && in_ready`.
- `in_values`  in  `[NUM_CHANNELS-1:0][VALUE_WIDTH-1:0]`  spike onset phase per channel.
- `in_mask`  in  `NUM_CHANNELS`  1 = channel spikes; 0 = channel silent (the "no spike"/infinity code).
- `spikes`  out  `NUM_CHANNELS`  temporal outputs; driven directly from flops.
- `gamma_start`  out  1  high during the phase-0 cycle of every gamma cycle.
- `underrun`  out  1  one-cycle pulse at phase 0 when no new data was available at the boundary.

## Operation
- `phase` counter, `VALUE_WIDTH` bits:
  - Increments every cycle.
  - Wraps from `GAMMA_CYCLE_WIDTH-1` to 0.
  - The wrap edge is the gamma boundary.
- Shadow buffer holds `pend_values`, `pend_mask` and `pend_valid`:
  - `in_ready = !pend_valid`.
  - An accepted transfer sets `pend_valid` and captures the data.
- Gamma boundary:
  - If `pend_valid`: active set ← pending, `active_valid` ← 1, `pend_valid` ← 0.
  - Otherwise: `active_valid` ← 0 and `underrun` pulses for the phase-0 cycle.
  - The active set is otherwise held constant.
- Simultaneous accept and boundary:
  - With `pend_valid=0`, data accepted on the wrap cycle is written to pending, not active, and is used in the following gamma cycle.
  - With `pend_valid=1`, `in_ready` is 0 on the wrap cycle and rises in the phase-0 cycle.
- Spike rule:
  - `spikes[i]=1` exactly in cycles where `active_valid && mask[i] && value[i] ≤ phase < value[i]+PULSE_WIDTH`.
  - Compare using `VALUE_WIDTH+1` bits, so the sum never overflows.
  - Pulses truncate at the gamma boundary and never wrap into the next gamma cycle.
- `gamma_start = (phase == 0)`, registered.

## Timing
- Reset values:
  - `phase=0`, `pend_valid=0`, `active_valid=0`.
  - `spikes=0`, `underrun=0`.
  - `in_ready=1`, `gamma_start=1`.
- Reset is asynchronous; assertion mid-gamma-cycle immediately clears all spikes and discards pending data.
- After reset release:
  - The first cycle is phase 0, with `gamma_start=1` and `underrun=0`.
  - The first gamma cycle after reset is silent and is not flagged as an underrun.
- Latency: data accepted in gamma cycle k is emitted in gamma cycle k+1. The first spike for value v appears in the cycle where `phase==v`, i.e. v cycles after that cycle's `gamma_start`.
- Spike output changes on the same clock edge as `phase`; there are no combinational paths from inputs to any output except none (`in_ready` is from a flop).
- Back-to-back streaming: one transfer per gamma cycle sustains with zero underruns.

## Test plan
- Reset:
  - Stimulus: release `grst_n` and hold `in_valid=0` for 40 cycles.
  - Required: `spikes=0`; `gamma_start` high at cycles 0, 16 and 32; `underrun` high at cycles 16 and 32 only.
- Basic encode:
  - Stimulus: accept values {0,3,9,15}, mask 4'b1111, in gamma 0.
  - Required in gamma 1:
    - ch0 high at phases 0-7.
    - ch1 high at phases 3-10.
    - ch2 high at phases 9-15 (truncated).
    - ch3 high at phase 15 only.
    - Nothing carries into gamma 2.
- Mask:
  - Stimulus: mask 4'b0101 with values all 2.
  - Required: ch0 and ch2 high at phases 2-9; ch1 and ch3 stay 0.
- Backpressure:
  - Stimulus: accept A at phase 4, then hold B valid.
  - Required: `in_ready` low until the phase-0 cycle; B is accepted then, A plays in gamma 1 and B plays in gamma 2.
- Wrap-cycle accept:
  - Stimulus: `in_valid` asserted only on the phase-15 cycle with `pend_valid=0`.
  - Required: data is not emitted in the immediately following gamma cycle; it is emitted in the one after, with `underrun` pulsing at the intervening boundary.
- Mid-cycle reset:
  - Stimulus: assert `grst_n=0` at phase 6 while ch0 is spiking.
  - Required: `spikes` drop to 0 asynchronously; after release, `phase` restarts at 0 and pending data is lost.
